// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM state type and column helpers for the inverse key schedule.
package aes_pkg;
  localparam int AES_KEY_W = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_NR = 10;
  // Byte r holds Rcon[r]; entry 0 is a zero pad so round 0 indexes cleanly.
  localparam logic [87:0] RCON = 88'h36_1b_80_40_20_10_08_04_02_01_00;
  typedef enum logic {IDLE, EMIT} state_e;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r > 4'd10) ? 8'h00 : RCON[{r, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p, s;
    p = '0;
    s = a;
    for (int j = 0; j < 4; j++) begin
      p = k[j] ? p ^ s : p;
      s = xt(s);
    end
    return p;
  endfunction
  function automatic logic [AES_WORD_W-1:0] inv_mixcol_word(input logic [AES_WORD_W-1:0] w);
    logic [7:0] b [4];
    logic [AES_WORD_W-1:0] r;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    for (int i = 0; i < 4; i++)
      r[31-8*i -: 8] = gmul(b[i], 4'he) ^ gmul(b[(i+1)%4], 4'hb) ^ gmul(b[(i+2)%4], 4'hd) ^ gmul(b[(i+3)%4], 4'h9);
    return r;
  endfunction
endpackage

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: one combinational backwards step of the AES-128 key schedule (round r -> r-1).
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key,
  input  logic [3:0]           round,
  output logic [AES_KEY_W-1:0] prev_key
);
  logic [AES_WORD_W-1:0] a, b, c, d, dn, rw, sw;
  assign {a, b, c, d} = key;
  assign dn = d ^ c;
  assign rw = {dn[23:0], dn[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sb
    sbox1 u_sbox (.a_i(rw[8*i +: 8]), .y_o(sw[8*i +: 8]));
  end
  assign prev_key = {a ^ sw ^ {rcon(round), 24'h0}, b ^ a, c ^ b, dn};
endmodule

// File: rtl/sbox1.sv
// sbox1: combinational AES forward S-box, one byte in, one byte out.
module sbox1 (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y_o = SBOX[{~a_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_key_sched.sv
// aes_inv_key_sched: iterative AES-128 inverse key schedule, emits round keys 10..0 over valid/ready.
// Optional INV_KEY_MIXCOL_EN: rounds 9..1 are emitted InvMixColumns-transformed.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter bit SKIP_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [AES_KEY_W-1:0] key_out,
  output logic [3:0]           key_round,
  output logic                 busy,
  output logic                 done
);
  state_e state_q;
  logic [AES_KEY_W-1:0] key_q, step_key, prev_key;
  logic [3:0] round_q, step_round;
  logic valid_q, done_q;
  // The single step datapath serves both the optional load-time step and every later step.
  assign step_key = (state_q == IDLE) ? key_in : key_q;
  assign step_round = (state_q == IDLE) ? 4'(AES_NR) : round_q;
  aes_inv_key_step u_step (.key(step_key), .round(step_round), .prev_key(prev_key));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= EMIT;
          valid_q <= 1'b1;
          key_q <= SKIP_FIRST ? prev_key : key_in;
          round_q <= SKIP_FIRST ? 4'(AES_NR - 1) : 4'(AES_NR);
        end
      end else if (key_ready) begin
        if (round_q == 4'd0) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          key_q <= prev_key;
          round_q <= round_q - 4'd1;
        end
      end
    end
  end
  assign key_valid = valid_q;
  assign key_round = round_q;
  assign busy = (state_q == EMIT);
  assign done = done_q;
`ifdef INV_KEY_MIXCOL_EN
  logic mix;
  assign mix = (round_q != 4'd0) && (round_q != 4'(AES_NR));
  assign key_out = mix ? {inv_mixcol_word(key_q[127:96]), inv_mixcol_word(key_q[95:64]),
                          inv_mixcol_word(key_q[63:32]), inv_mixcol_word(key_q[31:0])} : key_q;
`else
  assign key_out = key_q;
`endif
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// tb_aes_inv_key_sched: scoreboard bench for both SKIP_FIRST builds using the FIPS-197 A.1 schedule.
module tb_aes_inv_key_sched;
  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0, sel = 1'b0;
  logic rnd_en = 1'b0, rnd = 1'b1, ready;
  logic [127:0] key_in = '0;
  logic v0, v1, b0, b1, d0, d1;
  logic [127:0] k0, k1;
  logic [3:0] r0, r1;
  logic mv, md;
  logic [127:0] mk;
  logic [3:0] mr;
  exp_t tab [11];
  exp_t sb [$];
  exp_t e;
  int errors = 0, checks = 0, acc = 0, cyc = 0, base = 0;
  logic held = 1'b0, done_exp = 1'b0;
  logic [127:0] hk;
  logic [3:0] hr;

  always #5 clk = ~clk;
  assign ready = rnd_en ? rnd : 1'b1;
  assign mv = sel ? v1 : v0;
  assign md = sel ? d1 : d0;
  assign mk = sel ? k1 : k0;
  assign mr = sel ? r1 : r0;

  aes_inv_key_sched #(.SKIP_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .key_in(key_in), .key_valid(v0), .key_ready(ready),
    .key_out(k0), .key_round(r0), .busy(b0), .done(d0));
  aes_inv_key_sched #(.SKIP_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key_in), .key_valid(v1), .key_ready(ready),
    .key_out(k1), .key_round(r1), .busy(b1), .done(d1));

  task automatic chk(input string n, input logic [127:0] g, input logic [127:0] x);
    checks++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, g, x);
    end
  endtask

`ifdef INV_KEY_MIXCOL_EN
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [31:0] imc(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {gm(s0,8'h0e)^gm(s1,8'h0b)^gm(s2,8'h0d)^gm(s3,8'h09),
            gm(s0,8'h09)^gm(s1,8'h0e)^gm(s2,8'h0b)^gm(s3,8'h0d),
            gm(s0,8'h0d)^gm(s1,8'h09)^gm(s2,8'h0e)^gm(s3,8'h0b),
            gm(s0,8'h0b)^gm(s1,8'h0d)^gm(s2,8'h09)^gm(s3,8'h0e)};
  endfunction
  function automatic logic [127:0] expk(input int r);
    logic [127:0] k = tab[r].key;
    return (r >= 1 && r <= 9) ? {imc(k[127:96]), imc(k[95:64]), imc(k[63:32]), imc(k[31:0])} : k;
  endfunction
`else
  function automatic logic [127:0] expk(input int r);
    return tab[r].key;
  endfunction
`endif

  // Scoreboard: a beat seen valid&&ready here is accepted on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
      done_exp = 1'b0;
    end else begin
      if (held) begin
        chk("hold_key", mk, hk);
        chk("hold_round", {124'h0, mr}, {124'h0, hr});
      end
      chk("done", {127'h0, md}, {127'h0, done_exp});
      done_exp = 1'b0;
      held = mv && !ready;
      hk = mk;
      hr = mr;
      if (mv && ready) begin
        acc++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat got round=%0d exp=none", mr);
        end else begin
          e = sb.pop_front();
          chk("round", {124'h0, mr}, {124'h0, e.round});
          chk("key", mk, expk(int'(e.round)));
          done_exp = (e.round == 4'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push_run(input bit skip);
    exp_t t;
    for (int r = skip ? 9 : 10; r >= 0; r--) begin
      t.round = 4'(r);
      t.key = '0;
      sb.push_back(t);
    end
  endtask
  task automatic go(input bit s1);
    if (s1) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      c++;
      if (md) return;
    end
    chk("done_timeout", 128'h0, 128'h1);
  endtask
  task automatic wait_acc(input int n);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (acc >= n) return;
    end
    chk("accept_timeout", 128'(acc), 128'(n));
  endtask

  always @(posedge clk) begin
    #2;
    rnd = ($urandom_range(0, 2) != 0);
  end

  initial begin
    tab[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tab[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    tab[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    tab[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    tab[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    tab[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    tab[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    tab[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    tab[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    tab[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tab[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    key_in = tab[10].key;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", {127'h0, v0 | v1}, 128'h0);
    chk("rst_busy", {127'h0, b0 | b1}, 128'h0);
    chk("rst_done", {127'h0, d0 | d1}, 128'h0);
    chk("rst_key", k0 | k1, 128'h0);
    chk("rst_round", {124'h0, r0 | r1}, 128'h0);
    tick();
    // Full-rate run: eleven consecutive beats, done on the 12th cycle after start.
    push_run(1'b0);
    go(1'b0);
    wait_done(cyc);
    chk("a1_cycles", 128'(cyc), 128'd12);
    tick();
    // Backpressure run
    rnd_en = 1'b1;
    push_run(1'b0);
    go(1'b0);
    wait_done(cyc);
    rnd_en = 1'b0;
    tick();
    // SKIP_FIRST build: starts at round 9, ten beats
    sel = 1'b1;
    tick();
    push_run(1'b1);
    go(1'b1);
    wait_done(cyc);
    chk("skip_cycles", 128'(cyc), 128'd11);
    tick();
    sel = 1'b0;
    tick();
    // Reset right after beat 4 is accepted
    base = acc;
    push_run(1'b0);
    go(1'b0);
    wait_acc(base + 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", {127'h0, v0}, 128'h0);
    chk("abort_busy", {127'h0, b0}, 128'h0);
    chk("abort_done", {127'h0, d0}, 128'h0);
    sb.delete();
    tick();
    push_run(1'b0);
    go(1'b0);
    wait_done(cyc);
    chk("restart_cycles", 128'(cyc), 128'd12);
    tick();
    // start while busy is ignored; start with done launches the next run at once
    base = acc;
    push_run(1'b0);
    go(1'b0);
    wait_acc(base + 4);
    tick();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    wait_acc(base + 11);
    tick();
    chk("b2b_done_now", {127'h0, d0}, 128'h1);
    push_run(1'b0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {127'h0, v0}, 128'h1);
    chk("b2b_round", {124'h0, r0}, 128'd10);
    wait_done(cyc);
    repeat (3) tick();
    chk("sb_empty", 128'(sb.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
